// File: rtl/cascade_count_pkg.sv
// -----------------------------------------------------------------------------
// cascade_count_pkg
//   Shared types and helpers for the cascaded modulo counter.
//   - dir_e     : count direction encoding (matches the i_dir pin level)
//   - MAX_STAGE : largest supported number of cascaded stages
//   - max_mod() : pairwise maximum, folded over the modulus list to size W
// -----------------------------------------------------------------------------
package cascade_count_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int MAX_STAGE = 8;

  function automatic int max_mod(input int a, input int b);
    int m;
    if (a > b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/cascade_count_stage.sv
// -----------------------------------------------------------------------------
// count_stage
//   One modulo-MODV up/down digit of the cascade.
//   Ports:
//     clk, areset_n  clock and asynchronous active-low reset
//     i_sclr         synchronous clear (highest priority)
//     i_load         synchronous load of i_load_val, clamped to MODV-1
//     i_load_val     W-bit load value for this stage
//     i_step         advance one position in direction i_dir
//     i_dir          0 = up, 1 = down
//     o_val          registered stage value
//     o_term         stage sits at its terminal value for the current i_dir
// -----------------------------------------------------------------------------
module count_stage
  import cascade_count_pkg::*;
#(
  parameter int MODV = 10,
  parameter int W    = 4
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         i_sclr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  input  logic         i_dir,
  output logic [W-1:0] o_val,
  output logic         o_term
);

  // Terminal value in up direction, evaluated in the stage's own width.
  localparam logic [W-1:0] TOP_V = W'(MODV - 1);

  logic [W-1:0] val_r;
  logic [W-1:0] load_clamp_s;
  logic         term_s;
  dir_e         dir_s;

  assign dir_s = dir_e'(i_dir);

  // Terminal detect for the direction requested this cycle.
  always_comb begin
    term_s = 1'b0;
    case (dir_s)
      DIR_UP:   term_s = (val_r == TOP_V);
      DIR_DOWN: term_s = (val_r == {W{1'b0}});
      default:  term_s = 1'b0;
    endcase
  end

  // Out-of-range load fields saturate to the highest legal digit.
  always_comb begin
    load_clamp_s = i_load_val;
    if (i_load_val > TOP_V) begin
      load_clamp_s = TOP_V;
    end else begin
      load_clamp_s = i_load_val;
    end
  end

  // Digit register: clear > load > step; wraps at either end of the range.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      val_r <= {W{1'b0}};
    end else if (i_sclr) begin
      val_r <= {W{1'b0}};
    end else if (i_load) begin
      val_r <= load_clamp_s;
    end else if (i_step) begin
      case (dir_s)
        DIR_UP:   val_r <= term_s ? {W{1'b0}} : (val_r + {{(W-1){1'b0}}, 1'b1});
        DIR_DOWN: val_r <= term_s ? TOP_V : (val_r - {{(W-1){1'b0}}, 1'b1});
        default:  val_r <= val_r;
      endcase
    end else begin
      val_r <= val_r;
    end
  end

  assign o_val  = val_r;
  assign o_term = term_s;

endmodule

// File: rtl/cascade_count.sv
// -----------------------------------------------------------------------------
// cascade_count
//   NSTAGE cascaded modulo counters (stage 0 least significant), each with its
//   own modulus, ripple-carry enabled, with direction, parallel load and
//   wrap (SAT=0) or saturate (SAT=1) behaviour at the chain terminal count.
//   Ports:
//     clk, areset_n  clock and asynchronous active-low reset
//     i_sclr         synchronous clear of all stages and o_wrap
//     i_enable       count request for stage 0
//     i_dir          0 = up, 1 = down
//     i_load         synchronous parallel load (clamped per stage)
//     i_load_val     load value, field k = [k*W +: W]
//     o_val          registered count, field k = stage k
//     o_tc           combinational terminal count of the whole chain
//     o_wrap         registered pulse: chain wrapped, or step blocked when SAT=1
// -----------------------------------------------------------------------------
module cascade_count
  import cascade_count_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int MOD [NSTAGE-1:0] = '{6, 10, 6, 10},
  parameter int SAT = 0,
  // Largest modulus; indices beyond NSTAGE fold back onto stage 0.
  localparam int MOD_MAX = max_mod(
      max_mod(max_mod(MOD[0], MOD[(NSTAGE > 32'd1) ? 32'd1 : 32'd0]),
              max_mod(MOD[(NSTAGE > 32'd2) ? 32'd2 : 32'd0],
                      MOD[(NSTAGE > 32'd3) ? 32'd3 : 32'd0])),
      max_mod(max_mod(MOD[(NSTAGE > 32'd4) ? 32'd4 : 32'd0],
                      MOD[(NSTAGE > 32'd5) ? 32'd5 : 32'd0]),
              max_mod(MOD[(NSTAGE > 32'd6) ? 32'd6 : 32'd0],
                      MOD[(NSTAGE > 32'd7) ? 32'd7 : 32'd0]))),
  localparam int W = $clog2(MOD_MAX)
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic                i_sclr,
  input  logic                i_enable,
  input  logic                i_dir,
  input  logic                i_load,
  input  logic [NSTAGE*W-1:0] i_load_val,
  output logic [NSTAGE*W-1:0] o_val,
  output logic                o_tc,
  output logic                o_wrap
);

  logic [NSTAGE-1:0] term_s;
  logic [NSTAGE-1:0] en_s;
  logic [NSTAGE-1:0] step_s;
  logic              tc_s;
  logic              block_s;
  logic              wrap_r;

  // Ripple enable: a stage steps only when every lower stage is terminal.
  always_comb begin
    logic carry_s;
    en_s    = {NSTAGE{1'b0}};
    carry_s = i_enable;
    for (int k = 0; k < NSTAGE; k++) begin
      en_s[k] = carry_s;
      carry_s = carry_s & term_s[k];
    end
  end

  assign tc_s = &term_s;

  // In saturate mode a step out of the terminal count is suppressed entirely.
  assign block_s = (SAT != 0) & i_enable & tc_s;
  assign step_s  = en_s & {NSTAGE{~block_s}};

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    count_stage #(
      .MODV (MOD[g]),
      .W    (W)
    ) u_stage (
      .clk        (clk),
      .areset_n   (areset_n),
      .i_sclr     (i_sclr),
      .i_load     (i_load),
      .i_load_val (i_load_val[g*W +: W]),
      .i_step     (step_s[g]),
      .i_dir      (i_dir),
      .o_val      (o_val[g*W +: W]),
      .o_term     (term_s[g])
    );
  end

  // Wrap/blocked pulse; the same condition covers both SAT modes.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wrap_r <= 1'b0;
    end else if (i_sclr || i_load) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= i_enable & tc_s;
    end
  end

  assign o_tc   = tc_s;
  assign o_wrap = wrap_r;

endmodule

// File: tb/tb_cascade_count.sv
// -----------------------------------------------------------------------------
// tb_cascade_count
//   Scoreboarded bench for cascade_count with default moduli '{6,10,6,10}.
//   Two instances share all inputs: u_dut0 wraps (SAT=0), u_dut1 saturates.
//   The driver queues the expected post-edge response of each cycle; the
//   monitor pops and compares one cycle later (or at once for async reset).
// -----------------------------------------------------------------------------
module tb_cascade_count;

  logic        clk;
  logic        areset_n;
  logic        sclr;
  logic        en;
  logic        dir;
  logic        load;
  logic [15:0] lval;
  logic [15:0] val0, val1;
  logic        tc0, tc1;
  logic        wrap0, wrap1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        sel;
    logic [15:0] val;
    logic        wrap;
    logic        chk_tc;
    logic        tc;
    logic [79:0] tag;
  } exp_t;

  exp_t exp_q[$];
  event mon_ev;

  cascade_count #(.SAT(0)) u_dut0 (
    .clk(clk), .areset_n(areset_n), .i_sclr(sclr), .i_enable(en), .i_dir(dir),
    .i_load(load), .i_load_val(lval), .o_val(val0), .o_tc(tc0), .o_wrap(wrap0)
  );

  cascade_count #(.SAT(1)) u_dut1 (
    .clk(clk), .areset_n(areset_n), .i_sclr(sclr), .i_enable(en), .i_dir(dir),
    .i_load(load), .i_load_val(lval), .o_val(val1), .o_tc(tc1), .o_wrap(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pack(input int d3, input int d2, input int d1, input int d0);
    return {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
  endfunction

  // Stopwatch digits mm:ss from an elapsed-seconds count.
  function automatic logic [15:0] mmss(input int n);
    int s;
    s = n % 3600;
    return pack(s / 600, (s / 60) % 10, (s % 60) / 10, s % 10);
  endfunction

  function automatic exp_t mk(input logic sel, input logic [15:0] v, input logic w,
                              input logic ctc, input logic tc, input logic [79:0] tag);
    exp_t e;
    e.sel = sel; e.val = v; e.wrap = w; e.chk_tc = ctc; e.tc = tc; e.tag = tag;
    return e;
  endfunction

  // Queue the response expected after the coming rising edge, then advance.
  task automatic expect_edge(input logic sel, input logic [15:0] v, input logic w,
                             input logic ctc, input logic tc, input logic [79:0] tag);
    exp_q.push_back(mk(sel, v, w, ctc, tc, tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compares queued expectations after each edge or on request.
  initial begin
    exp_t        e;
    logic [15:0] gv;
    logic        gw, gt;
    forever begin
      @(posedge clk or mon_ev);
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        gv = e.sel ? val1  : val0;
        gw = e.sel ? wrap1 : wrap0;
        gt = e.sel ? tc1   : tc0;
        checks++;
        if (gv !== e.val) begin
          errors++;
          $display("FAIL %0s o_val: got %h expected %h", e.tag, gv, e.val);
        end
        checks++;
        if (gw !== e.wrap) begin
          errors++;
          $display("FAIL %0s o_wrap: got %b expected %b", e.tag, gw, e.wrap);
        end
        if (e.chk_tc) begin
          checks++;
          if (gt !== e.tc) begin
            errors++;
            $display("FAIL %0s o_tc: got %b expected %b", e.tag, gt, e.tc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    areset_n = 1'b0; sclr = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; lval = 16'h0000;
    @(negedge clk);

    // Reset state; o_tc follows i_dir while all stages are zero.
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "rst_up");
    dir = 1'b1;
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, "rst_dn");
    expect_edge(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, "rst_sat");
    dir = 1'b0; areset_n = 1'b1;
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "idle");

    // Full hour up-count: single wrap pulse alongside 59:59 -> 00:00.
    en = 1'b1;
    for (int n = 1; n <= 3600; n++) begin
      expect_edge(1'b0, mmss(n), (n == 3600), 1'b1, ((n % 3600) == 3599), "up_run");
    end
    en = 1'b0;
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "hold");

    // Down count from 00:00 wraps to 59:59.
    dir = 1'b1;
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, "dn_tc");
    en = 1'b1;
    expect_edge(1'b0, pack(5, 9, 5, 9), 1'b1, 1'b1, 1'b0, "dn_wrap");
    expect_edge(1'b0, pack(5, 9, 5, 8), 1'b0, 1'b1, 1'b0, "dn_step");
    en = 1'b0;

    // Saturating instance holds at 59:59 and flags blocked steps.
    dir = 1'b0; load = 1'b1; lval = pack(5, 9, 5, 8);
    expect_edge(1'b1, pack(5, 9, 5, 8), 1'b0, 1'b1, 1'b0, "sat_load");
    load = 1'b0; en = 1'b1;
    expect_edge(1'b1, pack(5, 9, 5, 9), 1'b0, 1'b1, 1'b1, "sat_1");
    expect_edge(1'b1, pack(5, 9, 5, 9), 1'b1, 1'b1, 1'b1, "sat_2");
    expect_edge(1'b1, pack(5, 9, 5, 9), 1'b1, 1'b1, 1'b1, "sat_3");
    dir = 1'b1;
    expect_edge(1'b1, pack(5, 9, 5, 8), 1'b0, 1'b1, 1'b0, "sat_dn");
    en = 1'b0; dir = 1'b0;

    // Load clamping and priority: clear beats load and enable, load beats enable.
    load = 1'b1; lval = pack(7, 12, 9, 15);
    expect_edge(1'b0, pack(5, 9, 5, 9), 1'b0, 1'b1, 1'b1, "clamp");
    expect_edge(1'b1, pack(5, 9, 5, 9), 1'b0, 1'b1, 1'b1, "clamp_sat");
    sclr = 1'b1; en = 1'b1;
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "sclr_win");
    sclr = 1'b0; lval = pack(1, 2, 3, 4);
    expect_edge(1'b0, pack(1, 2, 3, 4), 1'b0, 1'b1, 1'b0, "load_win");
    load = 1'b0; en = 1'b0;

    // Asynchronous reset between edges while at 23:41.
    load = 1'b1; lval = pack(2, 3, 4, 0);
    expect_edge(1'b0, pack(2, 3, 4, 0), 1'b0, 1'b1, 1'b0, "pre_2340");
    load = 1'b0; en = 1'b1;
    expect_edge(1'b0, pack(2, 3, 4, 1), 1'b0, 1'b1, 1'b0, "pre_2341");
    #1 areset_n = 1'b0;
    #1;
    exp_q.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "async_rst"));
    exp_q.push_back(mk(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, "async_sat"));
    ->mon_ev;
    #2;
    expect_edge(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "rst_hold");
    areset_n = 1'b1;
    expect_edge(1'b0, pack(0, 0, 0, 1), 1'b0, 1'b1, 1'b0, "resume");
    en = 1'b0;

    // Direction toggling across the 09:59 / 10:00 carry boundary.
    load = 1'b1; lval = pack(0, 9, 5, 9);
    expect_edge(1'b0, pack(0, 9, 5, 9), 1'b0, 1'b1, 1'b0, "at_0959");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dir = (i % 2 == 1);
      if (i % 2 == 0) begin
        expect_edge(1'b0, pack(1, 0, 0, 0), 1'b0, 1'b1, 1'b0, "tog_up");
      end else begin
        expect_edge(1'b0, pack(0, 9, 5, 9), 1'b0, 1'b1, 1'b0, "tog_dn");
      end
    end
    en = 1'b0; dir = 1'b0;

    // Every queued expectation must have been consumed by the monitor.
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
